// File: rtl/isa_io_sequencer.sv
// ISA I/O bus-cycle sequencer: round-robin arbitration between two internal
// requesters, then one complete read or write cycle on the ISA I/O window
// with setup / strobe / IOCHRDY wait / hold phases. All outputs are registered.
module isa_io_sequencer #(
  parameter logic [9:0]  BASE       = 10'h2B0,
  parameter int unsigned SETUP_CYC  = 32'd2,
  parameter int unsigned STROBE_CYC = 32'd4,
  parameter int unsigned HOLD_CYC   = 32'd1,
  parameter int unsigned WAIT_MAX   = 32'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [1:0] ofs0,
  input  logic [1:0] ofs1,
  input  logic [7:0] wd0,
  input  logic [7:0] wd1,
  output logic       ack0,
  output logic       ack1,
  output logic       err,
  output logic [7:0] rd,
  output logic [9:0] sa,
  output logic [7:0] sd_o,
  output logic       sd_oe,
  input  logic [7:0] sd_i,
  output logic       ior_n,
  output logic       iow_n,
  output logic       aen,
  input  logic       iochrdy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_WAIT   = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Phase counters compare against "last cycle" index of each phase.
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 32'd1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 32'd1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 32'd1);
  localparam logic [7:0] WAIT_LAST   = 8'(WAIT_MAX - 32'd1);

  state_t     state_r, state_nxt_s;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic       gnt_r;       // id of the requester owning the current cycle
  logic       we_r;
  logic [1:0] ofs_r;
  logic       ptr_r;       // preferred requester when both request
  logic       tout_r;      // IOCHRDY timeout seen in this cycle

  logic       gnt_sel_s;
  logic       sel_we_s;
  logic [1:0] sel_ofs_s;
  logic [7:0] sel_wd_s;
  logic       grant_s;
  logic       cap_s;       // capture read data on this edge
  logic       tout_set_s;  // leaving WAIT on timeout this edge
  logic       cur_we_s;
  logic [1:0] cur_ofs_s;
  logic       owned_nxt_s;
  logic       strobe_nxt_s;

  // Round-robin pick: a lone requester always wins, a tie goes to ptr_r.
  always_comb begin
    gnt_sel_s = 1'b0;
    if (req0 && req1) begin
      gnt_sel_s = ptr_r;
    end else if (req1) begin
      gnt_sel_s = 1'b1;
    end else begin
      gnt_sel_s = 1'b0;
    end
  end

  assign sel_we_s  = gnt_sel_s ? we1  : we0;
  assign sel_ofs_s = gnt_sel_s ? ofs1 : ofs0;
  assign sel_wd_s  = gnt_sel_s ? wd1  : wd0;

  // Next-state and phase-counter logic for the bus-cycle FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + 8'd1;
    grant_s     = 1'b0;
    cap_s       = 1'b0;
    tout_set_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_nxt_s = 8'd0;
        if (req0 || req1) begin
          state_nxt_s = S_SETUP;
          grant_s     = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_nxt_s = S_STROBE;
          cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = S_SETUP;
        end
      end
      S_STROBE: begin
        if (cnt_r == STROBE_LAST) begin
          cnt_nxt_s = 8'd0;
          if (iochrdy) begin
            state_nxt_s = S_HOLD;
            cap_s       = 1'b1;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end else begin
          state_nxt_s = S_STROBE;
        end
      end
      S_WAIT: begin
        if (iochrdy) begin
          state_nxt_s = S_HOLD;
          cnt_nxt_s   = 8'd0;
          cap_s       = 1'b1;
        end else if (cnt_r == WAIT_LAST) begin
          state_nxt_s = S_HOLD;
          cnt_nxt_s   = 8'd0;
          tout_set_s  = 1'b1;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          state_nxt_s = S_DONE;
          cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = S_HOLD;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 8'd0;
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // On the grant edge the latched attributes are not yet valid, so use the mux.
  assign cur_we_s     = grant_s ? sel_we_s  : we_r;
  assign cur_ofs_s    = grant_s ? sel_ofs_s : ofs_r;
  assign owned_nxt_s  = (state_nxt_s == S_SETUP) || (state_nxt_s == S_STROBE) ||
                        (state_nxt_s == S_WAIT)  || (state_nxt_s == S_HOLD);
  assign strobe_nxt_s = (state_nxt_s == S_STROBE) || (state_nxt_s == S_WAIT);

  // State, request latches and all bus outputs registered from next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= 8'd0;
      gnt_r   <= 1'b0;
      we_r    <= 1'b0;
      ofs_r   <= 2'd0;
      ptr_r   <= 1'b0;
      tout_r  <= 1'b0;
      sa      <= 10'd0;
      sd_o    <= 8'd0;
      sd_oe   <= 1'b0;
      aen     <= 1'b1;
      ior_n   <= 1'b1;
      iow_n   <= 1'b1;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
      rd      <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (grant_s) begin
        gnt_r <= gnt_sel_s;
        we_r  <= sel_we_s;
        ofs_r <= sel_ofs_s;
      end
      if (grant_s) begin
        tout_r <= 1'b0;
      end else if (tout_set_s) begin
        tout_r <= 1'b1;
      end
      if (state_r == S_DONE) begin
        ptr_r <= ~gnt_r;
      end
      if (grant_s && sel_we_s) begin
        sd_o <= sel_wd_s;
      end
      sa    <= owned_nxt_s ? (BASE + {8'd0, cur_ofs_s}) : 10'd0;
      aen   <= ~owned_nxt_s;
      sd_oe <= owned_nxt_s & cur_we_s;
      iow_n <= ~(strobe_nxt_s & cur_we_s);
      ior_n <= ~(strobe_nxt_s & ~cur_we_s);
      ack0  <= (state_nxt_s == S_DONE) & ~gnt_r;
      ack1  <= (state_nxt_s == S_DONE) & gnt_r;
      err   <= (state_nxt_s == S_DONE) & tout_r;
      if (cap_s && !we_r) begin
        rd <= sd_i;
      end else if (tout_set_s && !we_r) begin
        rd <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_isa_io_sequencer.sv
// Directed bench for isa_io_sequencer: a table of single transactions with
// hand-computed timing/data, plus contention and mid-cycle reset sequences.
module tb_isa_io_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, req0, req1, we0, we1, iochrdy;
  logic [1:0] ofs0, ofs1;
  logic [7:0] wd0, wd1, sd_i;
  logic       ack0, ack1, err, sd_oe, ior_n, iow_n, aen;
  logic [7:0] rd, sd_o;
  logic [9:0] sa;

  int nvec = 0;
  int nbad = 0;

  typedef struct {
    logic       sel;      // requester 0/1
    logic       we;
    logic [1:0] ofs;
    logic [7:0] wd;
    logic [7:0] sdi;
    int         rdy_low;  // IOCHRDY low cycles starting at last strobe cycle
    logic [9:0] exp_sa;
    int         exp_stb;  // strobe low cycles
    int         exp_ack;  // ACK cycle, REQ cycle counted as 1
    logic       exp_err;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  isa_io_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .ofs0(ofs0), .ofs1(ofs1), .wd0(wd0), .wd1(wd1),
    .ack0(ack0), .ack1(ack1), .err(err), .rd(rd),
    .sa(sa), .sd_o(sd_o), .sd_oe(sd_oe), .sd_i(sd_i),
    .ior_n(ior_n), .iow_n(iow_n), .aen(aen), .iochrdy(iochrdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int cyc, aen_cnt, first_aen, first_stb, stb_cnt, ack_cyc;
    int sa_bad, oe_bad, sdo_bad, idle_bad, stb_bad, err_stray;
    logic done, gerr;
    logic [1:0] ackv;
    logic [7:0] grd;
    string p;
    p = $sformatf("v%0d_", idx);
    cyc = 1; aen_cnt = 0; first_aen = 0; first_stb = 0; stb_cnt = 0; ack_cyc = 0;
    sa_bad = 0; oe_bad = 0; sdo_bad = 0; idle_bad = 0; stb_bad = 0; err_stray = 0;
    done = 1'b0; gerr = 1'b0; ackv = 2'b00; grd = 8'h00;
    req0 = (v.sel == 1'b0); req1 = (v.sel == 1'b1);
    we0 = v.we; we1 = v.we; ofs0 = v.ofs; ofs1 = v.ofs; wd0 = v.wd; wd1 = v.wd;
    sd_i = v.sdi; iochrdy = 1'b1;
    while (!done && cyc < 80) begin
      step();
      cyc++;
      if (!aen) begin
        if (first_aen == 0) first_aen = cyc;
        aen_cnt++;
        if (sa !== v.exp_sa) sa_bad++;
        if (sd_oe !== v.we) oe_bad++;
        if (v.we && sd_o !== v.wd) sdo_bad++;
      end else if (sd_oe !== 1'b0 || sa !== 10'd0) begin
        idle_bad++;
      end
      if (!ior_n || !iow_n) begin
        stb_cnt++;
        if (first_stb == 0) first_stb = cyc;
        if ((!ior_n && !iow_n) || (v.we ? !ior_n : !iow_n)) stb_bad++;
        iochrdy = !(stb_cnt >= 4 && stb_cnt < 4 + v.rdy_low);
      end else begin
        iochrdy = 1'b1;
      end
      if (ack0 || ack1) begin
        done = 1'b1; ack_cyc = cyc; ackv = {ack0, ack1}; gerr = err; grd = rd;
        req0 = 1'b0; req1 = 1'b0;
      end else if (err) begin
        err_stray++;
      end
    end
    chk({p, "ack_seen"}, 32'(done), 32'd1);
    chk({p, "ack_cycle"}, ack_cyc, v.exp_ack);
    chk({p, "ack_owner"}, 32'(ackv), v.sel ? 32'd1 : 32'd2);
    chk({p, "strobe_len"}, stb_cnt, v.exp_stb);
    chk({p, "aen_fall_cycle"}, first_aen, 32'd2);
    chk({p, "strobe_start_cycle"}, first_stb, 32'd4);
    chk({p, "aen_low_len"}, aen_cnt, v.exp_stb + 3);
    chk({p, "sa_bad_cycles"}, sa_bad, 32'd0);
    chk({p, "sd_oe_bad_cycles"}, oe_bad, 32'd0);
    chk({p, "sd_o_bad_cycles"}, sdo_bad, 32'd0);
    chk({p, "idle_bus_bad_cycles"}, idle_bad, 32'd0);
    chk({p, "strobe_bad_cycles"}, stb_bad, 32'd0);
    chk({p, "err"}, 32'(gerr), 32'(v.exp_err));
    chk({p, "rd"}, 32'(grd), 32'(v.exp_rd));
    chk({p, "stray_err"}, err_stray, 32'd0);
    step();
    chk({p, "ack_one_cycle"}, 32'({ack0, ack1, err}), 32'd0);
    chk({p, "aen_after_done"}, 32'(aen), 32'd1);
  endtask

  // Global time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int nack, gap, cyc;
    logic in_own, own_oe, who, seen;
    logic [9:0] own_sa;
    logic [7:0] own_sdo;

    vecs[0] = '{1'b0, 1'b1, 2'd2, 8'h5A, 8'h00, 0,   10'h2B2, 4,  9,  1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 8'h00, 8'hC3, 0,   10'h2B0, 4,  9,  1'b0, 8'hC3};
    vecs[2] = '{1'b0, 1'b0, 2'd3, 8'h00, 8'h3C, 3,   10'h2B3, 7,  12, 1'b0, 8'h3C};
    vecs[3] = '{1'b1, 1'b0, 2'd1, 8'h00, 8'h55, 255, 10'h2B1, 20, 25, 1'b1, 8'hFF};
    vecs[4] = '{1'b1, 1'b1, 2'd1, 8'hA5, 8'h00, 2,   10'h2B1, 6,  11, 1'b0, 8'hFF};
    vecs[5] = '{1'b0, 1'b1, 2'd0, 8'h3C, 8'h12, 255, 10'h2B0, 20, 25, 1'b1, 8'hFF};
    vecs[6] = '{1'b0, 1'b0, 2'd2, 8'h00, 8'h81, 16,  10'h2B2, 20, 25, 1'b0, 8'h81};

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    ofs0 = 2'd0; ofs1 = 2'd0; wd0 = 8'h00; wd1 = 8'h00; sd_i = 8'h00; iochrdy = 1'b1;
    @(negedge clk);
    step();
    step();
    chk("rst_strobes", 32'({ior_n, iow_n}), 32'd3);
    chk("rst_aen", 32'(aen), 32'd1);
    chk("rst_sa", 32'(sa), 32'd0);
    chk("rst_sd_o", 32'(sd_o), 32'd0);
    chk("rst_sd_oe", 32'(sd_oe), 32'd0);
    chk("rst_ack_err", 32'({ack0, ack1, err}), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], i);
    end

    // Contention: reset, then both requesters held; order must be 0,1,0,1.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b1; ofs0 = 2'd1; wd0 = 8'h11;
    req1 = 1'b1; we1 = 1'b0; ofs1 = 2'd3; wd1 = 8'hEE;
    sd_i = 8'h77; iochrdy = 1'b1;
    nack = 0; gap = 0; cyc = 0; in_own = 1'b0; own_oe = 1'b0;
    own_sa = 10'd0; own_sdo = 8'h00;
    while (nack < 4 && cyc < 100) begin
      step();
      cyc++;
      if (!aen) begin
        if (!in_own) begin
          in_own = 1'b1; own_sa = sa; own_oe = sd_oe; own_sdo = sd_o;
          if (nack > 0) chk($sformatf("cont_gap%0d", nack), 32'(gap >= 2), 32'd1);
        end
      end else begin
        in_own = 1'b0;
        gap++;
      end
      if (!aen) gap = 0;
      if (ack0 || ack1) begin
        who = ack1;
        chk($sformatf("cont_owner%0d", nack), 32'({ack0, ack1}), nack[0] ? 32'd1 : 32'd2);
        chk($sformatf("cont_sa%0d", nack), 32'(own_sa), who ? 32'h2B3 : 32'h2B1);
        chk($sformatf("cont_sd_oe%0d", nack), 32'(own_oe), who ? 32'd0 : 32'd1);
        if (who) chk($sformatf("cont_rd%0d", nack), 32'(rd), 32'h77);
        else chk($sformatf("cont_sd_o%0d", nack), 32'(own_sdo), 32'h11);
        nack++;
      end
    end
    chk("cont_ack_count", nack, 32'd4);
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();

    // Mid-cycle reset during the strobe of a write.
    req0 = 1'b1; we0 = 1'b1; ofs0 = 2'd2; wd0 = 8'hE7;
    cyc = 0;
    while (iow_n && cyc < 20) begin
      step();
      cyc++;
    end
    chk("mrst_reached_strobe", 32'(iow_n), 32'd0);
    rst_n = 1'b0;
    req1 = 1'b1; we1 = 1'b0; ofs1 = 2'd0;
    step();
    chk("mrst_iow_n", 32'(iow_n), 32'd1);
    chk("mrst_aen", 32'(aen), 32'd1);
    chk("mrst_sd_oe", 32'(sd_oe), 32'd0);
    chk("mrst_no_ack", 32'({ack0, ack1}), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 30) begin
      step();
      cyc++;
      if (ack0 || ack1) begin
        seen = 1'b1;
        chk("mrst_first_grant", 32'({ack0, ack1}), 32'd2);
        chk("mrst_ack_cycle", cyc, 32'd8);
      end
    end
    chk("mrst_ack_seen", 32'(seen), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
